// File: rtl/parking_gate_controller.sv
// parking_gate_controller: drives the parking barrier from the upstream access
// FSM state code and the lane sensors, and tracks lot occupancy.
// Optional feature macro: PARKING_LOCKOUT_EN. When it is defined, repeated
// wrong-password attempts lock out entry for LOCKOUT_CYCLES clocks.
module parking_gate_controller #(
  parameter int CAPACITY       = 8,
  parameter int CNT_W          = 4,
  parameter int OPEN_CYCLES    = 16,
  parameter int MAX_WRONG      = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       fsm_state,
  input  logic             back_sensor,
  input  logic             exit_sensor,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             reject,
  output logic             lockout
);

  typedef enum logic [1:0] {
    GATE_CLOSED   = 2'b00,
    GATE_OPEN_IN  = 2'b01,
    GATE_OPEN_OUT = 2'b10
  } gate_state_t;

  localparam logic [2:0]       ST_RIGHT    = 3'b010;
  localparam int               TMR_W       = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] OPEN_LAST_C = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_C       = CNT_W'(CAPACITY);

  // Reject parameter sets the counters cannot represent.
  if ((2 ** CNT_W) <= CAPACITY || OPEN_CYCLES < 2 || MAX_WRONG < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("parking_gate_controller: invalid parameter set");
  end

  gate_state_t      state_r, state_nxt_s;
  logic [2:0]       prev_state_r;
  logic             entry_pend_r, pend_nxt_s;
  logic [TMR_W-1:0] timer_r, timer_nxt_s;
  logic [CNT_W-1:0] occupancy_r, occ_nxt_s;
  logic             gate_open_r, full_r, reject_r, reject_nxt_s;
  logic             grant_edge_s, entry_req_s, lockout_s;

  assign grant_edge_s = (fsm_state == ST_RIGHT) && (prev_state_r != ST_RIGHT);
  // A fresh grant is acted on in the same cycle so the barrier opens one clock after the edge.
  assign entry_req_s  = entry_pend_r | grant_edge_s;

  // Gate FSM next state, passage timer, occupancy update and reject decision.
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    occ_nxt_s    = occupancy_r;
    pend_nxt_s   = entry_req_s;
    reject_nxt_s = 1'b0;
    case (state_r)
      GATE_CLOSED: begin
        if (entry_req_s && (occupancy_r < CAP_C) && !lockout_s) begin
          state_nxt_s = GATE_OPEN_IN;
          timer_nxt_s = '0;
          pend_nxt_s  = 1'b0;
        end else if (entry_req_s) begin
          reject_nxt_s = 1'b1;
          pend_nxt_s   = 1'b0;
        end else if (exit_sensor && (occupancy_r != '0)) begin
          state_nxt_s = GATE_OPEN_OUT;
          timer_nxt_s = '0;
          occ_nxt_s   = occupancy_r - CNT_W'(1);
        end else begin
          state_nxt_s = GATE_CLOSED;
        end
      end
      GATE_OPEN_IN: begin
        if (back_sensor) begin
          state_nxt_s = GATE_CLOSED;
          if (occupancy_r < CAP_C) begin
            occ_nxt_s = occupancy_r + CNT_W'(1);
          end else begin
            occ_nxt_s = occupancy_r;
          end
        end else if (timer_r == OPEN_LAST_C) begin
          // Car never passed the sensor: close without counting it.
          state_nxt_s = GATE_CLOSED;
        end else begin
          timer_nxt_s = timer_r + TMR_W'(1);
        end
      end
      GATE_OPEN_OUT: begin
        if (timer_r == OPEN_LAST_C) begin
          state_nxt_s = GATE_CLOSED;
        end else begin
          timer_nxt_s = timer_r + TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s = GATE_CLOSED;
        timer_nxt_s = '0;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // Register gate state and all gate-related outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= GATE_CLOSED;
      prev_state_r <= 3'b000;
      entry_pend_r <= 1'b0;
      timer_r      <= '0;
      occupancy_r  <= '0;
      gate_open_r  <= 1'b0;
      full_r       <= 1'b0;
      reject_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_state_r <= fsm_state;
      entry_pend_r <= pend_nxt_s;
      timer_r      <= timer_nxt_s;
      occupancy_r  <= occ_nxt_s;
      gate_open_r  <= (state_nxt_s != GATE_CLOSED);
      full_r       <= (occ_nxt_s == CAP_C);
      reject_r     <= reject_nxt_s;
    end
  end

  assign gate_open = gate_open_r;
  assign occupancy = occupancy_r;
  assign full      = full_r;
  assign reject    = reject_r;

`ifdef PARKING_LOCKOUT_EN
  localparam logic [2:0] ST_WRONG    = 3'b011;
  localparam int         WC_W        = ($clog2(MAX_WRONG + 1) < 2) ? 2 : $clog2(MAX_WRONG + 1);
  localparam int         LT_W        = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [WC_W-1:0] WRONG_LAST_C = WC_W'(MAX_WRONG - 1);
  localparam logic [WC_W-1:0] WRONG_MAX_C  = WC_W'(MAX_WRONG);
  localparam logic [LT_W-1:0] LOCK_LAST_C  = LT_W'(LOCKOUT_CYCLES - 1);

  logic            wrong_edge_s;
  logic [WC_W-1:0] wrong_cnt_r, wrong_cnt_nxt_s;
  logic [LT_W-1:0] lock_tmr_r, lock_tmr_nxt_s;
  logic            lockout_r, lockout_nxt_s;

  assign wrong_edge_s = (fsm_state == ST_WRONG) && (prev_state_r != ST_WRONG);

  // Wrong-attempt counting and lockout timing; grants during lockout leave the count alone.
  always_comb begin
    wrong_cnt_nxt_s = wrong_cnt_r;
    lock_tmr_nxt_s  = lock_tmr_r;
    lockout_nxt_s   = lockout_r;
    if (lockout_r) begin
      if (lock_tmr_r == LOCK_LAST_C) begin
        lockout_nxt_s   = 1'b0;
        wrong_cnt_nxt_s = '0;
        lock_tmr_nxt_s  = '0;
      end else begin
        lock_tmr_nxt_s = lock_tmr_r + LT_W'(1);
      end
    end else if (grant_edge_s) begin
      wrong_cnt_nxt_s = '0;
    end else if (wrong_edge_s) begin
      if (wrong_cnt_r >= WRONG_LAST_C) begin
        wrong_cnt_nxt_s = WRONG_MAX_C;
        lockout_nxt_s   = 1'b1;
        lock_tmr_nxt_s  = '0;
      end else begin
        wrong_cnt_nxt_s = wrong_cnt_r + WC_W'(1);
      end
    end else begin
      wrong_cnt_nxt_s = wrong_cnt_r;
    end
  end

  // Register lockout state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrong_cnt_r <= '0;
      lock_tmr_r  <= '0;
      lockout_r   <= 1'b0;
    end else begin
      wrong_cnt_r <= wrong_cnt_nxt_s;
      lock_tmr_r  <= lock_tmr_nxt_s;
      lockout_r   <= lockout_nxt_s;
    end
  end

  assign lockout_s = lockout_r;
  assign lockout   = lockout_r;
`else
  assign lockout_s = 1'b0;
  assign lockout   = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed testbench for parking_gate_controller (default parameters).
module tb_parking_gate_controller;

  logic       clock, reset;
  logic [2:0] fsm_state;
  logic       back_sensor, exit_sensor;
  logic       gate_open, full, reject, lockout;
  logic [3:0] occupancy;
  int         n_cmp, n_err;

  parking_gate_controller dut (
    .clock(clock), .reset(reset), .fsm_state(fsm_state),
    .back_sensor(back_sensor), .exit_sensor(exit_sensor),
    .gate_open(gate_open), .occupancy(occupancy), .full(full),
    .reject(reject), .lockout(lockout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Grant, wait one clock, then the car passes the back sensor.
  task automatic do_entry();
    fsm_state = 3'b010; tick();
    fsm_state = 3'b000; tick();
    back_sensor = 1'b1; tick();
    back_sensor = 1'b0;
  endtask

  // Car leaves; barrier stays open the full passage window.
  task automatic do_exit();
    exit_sensor = 1'b1; tick();
    exit_sensor = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; fsm_state = 3'b000; back_sensor = 1'b0; exit_sensor = 1'b0;
    repeat (2) tick();
    n_cmp++; if ({gate_open, occupancy, full, reject, lockout} !== 8'h00) begin n_err++; $display("FAIL reset_outs: got %h want 00", {gate_open, occupancy, full, reject, lockout}); end
    reset = 1'b0; tick();
    n_cmp++; if ({gate_open, occupancy, full, reject, lockout} !== 8'h00) begin n_err++; $display("FAIL post_reset_outs: got %h want 00", {gate_open, occupancy, full, reject, lockout}); end
  endtask

  task automatic test_entry();
    fsm_state = 3'b010; tick();
    n_cmp++; if (gate_open !== 1'b1) begin n_err++; $display("FAIL entry_open_latency: got %b want 1", gate_open); end
    fsm_state = 3'b000; tick(); tick();
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL entry_no_early_inc: got %0d want 0", occupancy); end
    back_sensor = 1'b1; tick(); back_sensor = 1'b0;
    n_cmp++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL entry_occ: got %0d want 1", occupancy); end
    n_cmp++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL entry_close: got %b want 0", gate_open); end
  endtask

  task automatic test_abandon();
    int cnt;
    fsm_state = 3'b010; tick(); fsm_state = 3'b000;
    cnt = (gate_open === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gate_open === 1'b1) cnt++;
      else break;
    end
    n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL abandon_open_len: got %0d want 16", cnt); end
    n_cmp++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL abandon_occ: got %0d want 1", occupancy); end
  endtask

  task automatic test_full();
    repeat (7) do_entry();
    n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ: got %0d want 8", occupancy); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", full); end
    fsm_state = 3'b010; tick();
    n_cmp++; if (reject !== 1'b1) begin n_err++; $display("FAIL full_reject: got %b want 1", reject); end
    n_cmp++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL full_gate: got %b want 0", gate_open); end
    fsm_state = 3'b000; tick();
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL full_reject_pulse: got %b want 0", reject); end
    n_cmp++; if (occupancy !== 4'd8 || gate_open !== 1'b0) begin n_err++; $display("FAIL full_hold: got occ %0d gate %b want 8 0", occupancy, gate_open); end
    exit_sensor = 1'b1; tick(); exit_sensor = 1'b0;
    n_cmp++; if ({occupancy, full, gate_open} !== {4'd7, 1'b0, 1'b1}) begin n_err++; $display("FAIL exit_first: got occ %0d full %b gate %b want 7 0 1", occupancy, full, gate_open); end
    repeat (16) tick();
    n_cmp++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL exit_close: got %b want 0", gate_open); end
    repeat (5) do_exit();
    n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL exit_drain: got %0d want 2", occupancy); end
  endtask

  task automatic test_priority();
    fsm_state = 3'b010; exit_sensor = 1'b1; tick();
    n_cmp++; if ({gate_open, occupancy} !== {1'b1, 4'd2}) begin n_err++; $display("FAIL prio_entry_first: got gate %b occ %0d want 1 2", gate_open, occupancy); end
    fsm_state = 3'b000; tick();
    back_sensor = 1'b1; tick(); back_sensor = 1'b0;
    n_cmp++; if ({gate_open, occupancy} !== {1'b0, 4'd3}) begin n_err++; $display("FAIL prio_in_done: got gate %b occ %0d want 0 3", gate_open, occupancy); end
    tick(); exit_sensor = 1'b0;
    n_cmp++; if ({gate_open, occupancy} !== {1'b1, 4'd2}) begin n_err++; $display("FAIL prio_exit_after: got gate %b occ %0d want 1 2", gate_open, occupancy); end
    repeat (16) tick();
    n_cmp++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL prio_exit_close: got %b want 0", gate_open); end
  endtask

  task automatic test_lockout();
    int lk;
    for (int i = 0; i < 3; i++) begin
      fsm_state = 3'b001; tick();
      fsm_state = 3'b011; tick();
`ifdef PARKING_LOCKOUT_EN
      if (i == 1) begin
        n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", lockout); end
      end
`endif
    end
`ifdef PARKING_LOCKOUT_EN
    n_cmp++; if (lockout !== 1'b1) begin n_err++; $display("FAIL lock_set: got %b want 1", lockout); end
    lk = 1;
    fsm_state = 3'b010; tick();
    if (lockout === 1'b1) lk++;
    n_cmp++; if ({reject, gate_open} !== 2'b10) begin n_err++; $display("FAIL lock_reject: got rej %b gate %b want 1 0", reject, gate_open); end
    fsm_state = 3'b000;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (lockout === 1'b1) lk++;
      else break;
    end
    n_cmp++; if (lk !== 64) begin n_err++; $display("FAIL lock_len: got %0d want 64", lk); end
    // Two wrongs, a grant (clears count), then one wrong must not lock.
    for (int i = 0; i < 2; i++) begin
      fsm_state = 3'b001; tick(); fsm_state = 3'b011; tick();
    end
    fsm_state = 3'b010; tick();
    n_cmp++; if (gate_open !== 1'b1) begin n_err++; $display("FAIL lock_grant_after: got %b want 1", gate_open); end
    fsm_state = 3'b011; tick(); fsm_state = 3'b000;
    n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("FAIL lock_cnt_clear: got %b want 0", lockout); end
    repeat (16) tick();
`else
    lk = 0;
    n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("FAIL nolock_tied: got %b want 0", lockout); end
    fsm_state = 3'b010; tick(); fsm_state = 3'b000;
    n_cmp++; if ({gate_open, reject} !== 2'b10) begin n_err++; $display("FAIL nolock_grant: got gate %b rej %b want 1 0", gate_open, reject); end
    repeat (16) tick();
`endif
    n_cmp++; if ({gate_open, occupancy} !== {1'b0, 4'd2}) begin n_err++; $display("FAIL lock_end_state: got gate %b occ %0d want 0 2", gate_open, occupancy); end
  endtask

  task automatic test_reset_mid();
    repeat (3) do_entry();
    fsm_state = 3'b010; tick(); fsm_state = 3'b000; tick();
    n_cmp++; if ({gate_open, occupancy} !== {1'b1, 4'd5}) begin n_err++; $display("FAIL mid_setup: got gate %b occ %0d want 1 5", gate_open, occupancy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({gate_open, occupancy} !== {1'b0, 4'd0}) begin n_err++; $display("FAIL mid_async_reset: got gate %b occ %0d want 0 0", gate_open, occupancy); end
    tick(); reset = 1'b0; tick();
    exit_sensor = 1'b1; tick(); exit_sensor = 1'b0;
    n_cmp++; if ({gate_open, occupancy} !== {1'b0, 4'd0}) begin n_err++; $display("FAIL empty_exit: got gate %b occ %0d want 0 0", gate_open, occupancy); end
    do_entry();
    n_cmp++; if ({gate_open, occupancy} !== {1'b0, 4'd1}) begin n_err++; $display("FAIL mid_recover: got gate %b occ %0d want 0 1", gate_open, occupancy); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_entry();
    test_abandon();
    test_full();
    test_priority();
    test_lockout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
